// File: rtl/arb_pkg.sv
// arb_pkg: shared arbiter state encoding and master-id type
package arb_pkg;
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
    typedef logic mid_t;
endpackage

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master (CPU=0, DMA=1) single-port memory arbiter with hold limit and bus lock
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   reqN/lockN            : master N request / hold-bus-past-limit
//   addrN/wdataN/weN      : master N address, write data, byte enables (0 = read)
//   gntN/stallN/rvalidN   : master N accepted / waiting / read data valid
//   rdata                 : shared read data (pass-through of data_read_mem)
//   addr_mem..en_mem      : memory port; data_read_mem returns one cycle after a read strobe
module bus_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        lock0,
    input  logic        lock1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic [3:0]  we0,
    input  logic [3:0]  we1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        stall0,
    output logic        stall1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata,
    output logic [31:0] addr_mem,
    output logic [31:0] data_write_mem,
    output logic [3:0]  data_we_mem,
    output logic        en_mem,
    input  logic [31:0] data_read_mem
);
    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_HOLD);
    state_t        state_q, state_d;
    mid_t          last_q, last_d, own;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          rvalid0_q, rvalid1_q;
    logic          req_own, req_oth, lock_own;
    // grants and read valids are masked by reset so outputs are quiet in the reset cycle itself
    assign gnt0           = ~reset & (state_q == OWN0) & req0;
    assign gnt1           = ~reset & (state_q == OWN1) & req1;
    assign stall0         = req0 & ~gnt0;
    assign stall1         = req1 & ~gnt1;
    assign en_mem         = gnt0 | gnt1;
    assign addr_mem       = gnt0 ? addr0 : gnt1 ? addr1 : '0;
    assign data_write_mem = gnt0 ? wdata0 : gnt1 ? wdata1 : '0;
    assign data_we_mem    = gnt0 ? we0 : gnt1 ? we1 : '0;
    assign rvalid0        = rvalid0_q & ~reset;
    assign rvalid1        = rvalid1_q & ~reset;
    assign rdata          = data_read_mem;
    assign own            = state_q == OWN1;
    assign req_own        = own ? req1 : req0;
    assign req_oth        = own ? req0 : req1;
    assign lock_own       = own ? lock1 : lock0;
    assign cnt_inc        = (cnt_q == MAX_C) ? cnt_q : cnt_q + 1'b1;
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE) begin
            if (req0 | req1)
                state_d = (req0 & (~req1 | last_q)) ? OWN0 : OWN1;
        end else if (!req_own) begin
            state_d = req_oth ? (own ? OWN0 : OWN1) : IDLE;
            cnt_d   = '0;
        end else begin
            last_d = own;
            cnt_d  = cnt_inc;
            // preemption goes through IDLE, which picks the other master since last = owner
            if (cnt_inc == MAX_C && !lock_own && req_oth) begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            rvalid0_q <= gnt0 & ~|we0;
            rvalid1_q <= gnt1 & ~|we1;
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: scoreboard bench for bus_arbiter against an ownership-level reference model
module tb_bus_arbiter;
    localparam int MH = 4;
    logic        clock = 1'b0, reset = 1'b1;
    logic        req0 = 0, req1 = 0, lock0 = 0, lock1 = 0;
    logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
    logic [3:0]  we0 = 0, we1 = 0;
    logic        gnt0, gnt1, stall0, stall1, rvalid0, rvalid1, en_mem;
    logic [31:0] rdata, addr_mem, data_write_mem, data_read_mem = 0;
    logic [3:0]  data_we_mem;

    bus_arbiter #(.MAX_HOLD(MH)) dut (
        .clock(clock), .reset(reset), .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1), .we0(we0), .we1(we1),
        .gnt0(gnt0), .gnt1(gnt1), .stall0(stall0), .stall1(stall1), .rvalid0(rvalid0),
        .rvalid1(rvalid1), .rdata(rdata), .addr_mem(addr_mem), .data_write_mem(data_write_mem),
        .data_we_mem(data_we_mem), .en_mem(en_mem), .data_read_mem(data_read_mem)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : a * 32'h9E3779B1 + 32'd1;
    endfunction

    // memory environment: read data appears one cycle after a read strobe
    always @(posedge clock)
        data_read_mem <= (en_mem && data_we_mem == 4'h0) ? mem_val(addr_mem) : $urandom;

    typedef struct {
        int cyc;
        logic g0, g1, s0, s1, en, rv0, rv1, rs;
        logic [3:0] we;
    } cyc_e;
    typedef struct {
        int cyc;
        int m;
        logic [31:0] a, d;
        logic [3:0] e;
    } bus_e;
    typedef struct {
        int cyc;
        int m;
        logic [31:0] d;
    } rd_e;

    cyc_e cq[$];
    bus_e bq[$];
    rd_e  rq[$];
    int   n_cmp = 0, n_bad = 0, cyc = 0;
    bit   run = 0;

    // reference model: owner (-1 = bus idle), last served, consecutive transfers this ownership
    int          own = -1, last = 1, streak = 0, pend_m = -1;
    logic [31:0] pend_a = 0;

    task automatic step(input bit rs, input bit q0, q1, k0, k1,
                        input logic [31:0] a0, a1, d0, d1, input logic [3:0] e0, e1);
        bit          rqv[2], lkv[2];
        logic [31:0] av[2], dv[2];
        logic [3:0]  ev[2];
        cyc_e        c;
        int          g, x, y;
        @(posedge clock);
        #1;
        reset = rs; req0 = q0; req1 = q1; lock0 = k0; lock1 = k1;
        addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1; we0 = e0; we1 = e1;
        rqv[0] = q0; rqv[1] = q1; lkv[0] = k0; lkv[1] = k1;
        av[0] = a0; av[1] = a1; dv[0] = d0; dv[1] = d1; ev[0] = e0; ev[1] = e1;
        cyc++;
        c.cyc = cyc; c.rs = rs; c.rv0 = 0; c.rv1 = 0;
        if (pend_m >= 0 && !rs) begin
            if (pend_m == 0) c.rv0 = 1; else c.rv1 = 1;
            rq.push_back('{cyc: cyc, m: pend_m, d: mem_val(pend_a)});
        end
        pend_m = -1;
        g = (!rs && own >= 0 && rqv[own]) ? own : -1;
        c.g0 = (g == 0); c.g1 = (g == 1);
        c.s0 = q0 && g != 0; c.s1 = q1 && g != 1;
        c.en = (g >= 0);
        c.we = (g >= 0) ? ev[g] : 4'h0;
        cq.push_back(c);
        if (g >= 0) begin
            bq.push_back('{cyc: cyc, m: g, a: av[g], d: dv[g], e: ev[g]});
            if (ev[g] == 4'h0) begin pend_m = g; pend_a = av[g]; end
        end
        if (rs) begin
            own = -1; last = 1; streak = 0;
        end else if (own < 0) begin
            if (q0 || q1) own = (q0 && q1) ? 1 - last : (q0 ? 0 : 1);
        end else begin
            x = own; y = 1 - own;
            if (!rqv[x]) begin
                own = rqv[y] ? y : -1;
                streak = 0;
            end else begin
                last = x;
                streak = (streak + 1 > MH) ? MH : streak + 1;
                if (streak == MH && !lkv[x] && rqv[y]) begin own = -1; streak = 0; end
            end
        end
    endtask

    // monitor: pops expectations as the DUT presents cycles, transfers and read data
    always @(negedge clock) if (run) begin
        cyc_e c;
        bus_e b;
        rd_e  r;
        if (cq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL cycle_queue: empty at time %0t", $time);
        end else begin
            c = cq.pop_front();
            n_cmp++;
            if ({gnt0, gnt1, stall0, stall1, en_mem, rvalid0, rvalid1, data_we_mem} !==
                {c.g0, c.g1, c.s0, c.s1, c.en, c.rv0, c.rv1, c.we}) begin
                n_bad++;
                $display("FAIL ctrl cyc %0d: got g%b%b s%b%b en%b rv%b%b we%h, want g%b%b s%b%b en%b rv%b%b we%h",
                         c.cyc, gnt0, gnt1, stall0, stall1, en_mem, rvalid0, rvalid1, data_we_mem,
                         c.g0, c.g1, c.s0, c.s1, c.en, c.rv0, c.rv1, c.we);
            end
            if (c.rs) begin
                n_cmp++;
                if ({addr_mem, data_write_mem} !== 64'h0) begin
                    n_bad++;
                    $display("FAIL reset_bus cyc %0d: got addr %h wdata %h, want 0 0", c.cyc, addr_mem, data_write_mem);
                end
            end
        end
        if (en_mem === 1'b1) begin
            n_cmp++;
            if (bq.size() == 0) begin
                n_bad++;
                $display("FAIL transfer cyc %0d: unexpected en_mem", cyc);
            end else begin
                b = bq.pop_front();
                if (cyc !== b.cyc || int'(gnt1) !== b.m || addr_mem !== b.a || data_write_mem !== b.d || data_we_mem !== b.e) begin
                    n_bad++;
                    $display("FAIL transfer: got cyc %0d m%0d a %h d %h e %h, want cyc %0d m%0d a %h d %h e %h",
                             cyc, gnt1, addr_mem, data_write_mem, data_we_mem, b.cyc, b.m, b.a, b.d, b.e);
                end
            end
        end
        if (rvalid0 === 1'b1 || rvalid1 === 1'b1) begin
            n_cmp++;
            if (rq.size() == 0) begin
                n_bad++;
                $display("FAIL read cyc %0d: unexpected rvalid %b%b", cyc, rvalid0, rvalid1);
            end else begin
                r = rq.pop_front();
                if (cyc !== r.cyc || int'(rvalid1) !== r.m || rdata !== r.d) begin
                    n_bad++;
                    $display("FAIL read: got cyc %0d m%0d rdata %h, want cyc %0d m%0d rdata %h",
                             cyc, rvalid1, rdata, r.cyc, r.m, r.d);
                end
            end
        end
    end

    task automatic idle(input int n, input bit rs);
        for (int i = 0; i < n; i++) step(rs, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bit q0 = 0, q1 = 0, k0 = 0, k1 = 0;
        run = 1;
        step(1, 1, 0, 0, 0, 32'h4, 32'h8, 1, 2, 4'h0, 4'h0);
        step(1, 0, 1, 0, 0, 32'h4, 32'h8, 1, 2, 4'h0, 4'h0);
        // simultaneous requests after reset, then master 0 drops
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 32'h10 + i, 32'h20 + i, 3, 4, 4'hF, 4'h3);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0, 32'h30 + i, 0, 5, 4'h0, 4'h1);
        idle(2, 1);
        // hold limit with contention, unlocked
        for (int i = 0; i < 12; i++) step(0, 1, 1, 0, 0, 32'h40 + i, 32'h50 + i, i, ~i, 4'h1, 4'h2);
        idle(2, 1);
        // locked owner ignores hold limit
        for (int i = 0; i < 22; i++) step(0, 1, 1, 1, 0, 32'h60 + i, 32'h70 + i, i, i, 4'hF, 4'hF);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0, 32'h80 + i, 0, i, 4'h0, 4'hF);
        idle(2, 1);
        // master 0 read of 0x100
        step(0, 1, 0, 0, 0, 32'h100, 0, 0, 0, 4'h0, 4'h0);
        step(0, 1, 0, 0, 0, 32'h100, 0, 0, 0, 4'h0, 4'h0);
        idle(2, 0);
        // master 1 full-word write
        step(0, 0, 1, 0, 0, 0, 32'h200, 0, 32'h12345678, 4'h0, 4'hF);
        step(0, 0, 1, 0, 0, 0, 32'h200, 0, 32'h12345678, 4'h0, 4'hF);
        idle(2, 0);
        // read granted, reset next cycle cancels it; then tie goes to master 0 again
        idle(1, 1);
        step(0, 1, 0, 0, 0, 32'h104, 0, 0, 0, 4'h0, 4'h0);
        step(0, 1, 0, 0, 0, 32'h104, 0, 0, 0, 4'h0, 4'h0);
        step(1, 1, 1, 0, 0, 32'h104, 32'h108, 0, 0, 4'h0, 4'h0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 32'h10C, 32'h110, 0, 0, 4'h0, 4'h0);
        // randomized traffic with sticky requests
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) < 2) q0 = ~q0;
            if ($urandom_range(0, 9) < 2) q1 = ~q1;
            if ($urandom_range(0, 19) == 0) k0 = ~k0;
            if ($urandom_range(0, 19) == 0) k1 = ~k1;
            step($urandom_range(0, 199) == 0, q0, q1, k0, k1, $urandom, $urandom, $urandom, $urandom,
                 ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                 ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)));
        end
        idle(3, 0);
        @(negedge clock);
        #1;
        run = 0;
        n_cmp++;
        if (cq.size() + bq.size() + rq.size() != 0) begin
            n_bad++;
            $display("FAIL leftover: got %0d/%0d/%0d unconsumed expectations, want 0/0/0", cq.size(), bq.size(), rq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
